// File: rtl/lamp_sqrt_radix_unit.sv
// Iterative mantissa square root: restoring digit recurrence producing
// MANT_W+GUARD_BITS root bits, BITS_PER_CYCLE bits per iteration cycle.
module lamp_sqrt_radix_unit #(
  parameter int unsigned LAMP_FLOAT_F_DW = 23,
  parameter int unsigned MANT_W          = 1 + LAMP_FLOAT_F_DW,
  parameter int unsigned GUARD_BITS      = 2,
  parameter int unsigned BITS_PER_CYCLE  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  doSqrt_i,
  input  logic [MANT_W-1:0]     s_i,
  input  logic                  is_exp_odd_i,
  input  logic                  special_case_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [MANT_W-1:0]     res_o,
  output logic [GUARD_BITS-1:0] guard_o,
  output logic                  sticky_o
);

  localparam int unsigned QW = MANT_W + GUARD_BITS;
  localparam int unsigned NW = 2 * QW;
  localparam int unsigned RW = QW + 3;
  localparam int unsigned C  = QW / BITS_PER_CYCLE;
  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
  localparam logic [CW-1:0] LAST = CW'(C - 1);

  generate
    if (((BITS_PER_CYCLE != 1) && (BITS_PER_CYCLE != 2)) || ((QW % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
      $error("lamp_sqrt_radix_unit: illegal BITS_PER_CYCLE for MANT_W+GUARD_BITS");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [NW-1:0]   rad;
  logic [RW-1:0]   rem;
  logic [QW-1:0]   root;

  logic [NW-1:0]   rad_nx;
  logic [RW-1:0]   rem_nx;
  logic [QW-1:0]   root_nx;
  logic [RW-1:0]   trial;
  logic [MANT_W:0] scaled;

  assign scaled  = is_exp_odd_i ? {s_i, 1'b0} : {1'b0, s_i};
  assign busy_o  = (state != IDLE);
  assign valid_o = (state == DONE);

  // Radicand is consumed two bits at a time from its MSB end per root bit.
  always_comb begin
    rad_nx  = rad;
    rem_nx  = rem;
    root_nx = root;
    trial   = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_nx = {rem_nx[RW-3:0], rad_nx[NW-1 -: 2]};
      trial  = {1'b0, root_nx, 2'b01};
      if (rem_nx >= trial) begin
        rem_nx  = rem_nx - trial;
        root_nx = {root_nx[QW-2:0], 1'b1};
      end else begin
        root_nx = {root_nx[QW-2:0], 1'b0};
      end
      rad_nx = {rad_nx[NW-3:0], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      res_o    <= '0;
      guard_o  <= '0;
      sticky_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (doSqrt_i && !flush_i) begin
            cnt  <= '0;
            rad  <= {scaled, {(MANT_W - 1 + 2 * GUARD_BITS){1'b0}}};
            rem  <= '0;
            root <= '0;
            if (special_case_i) begin
              state    <= DONE;
              res_o    <= '0;
              guard_o  <= '0;
              sticky_o <= 1'b0;
            end else begin
              state <= ITER;
            end
          end
        end
        ITER: begin
          if (flush_i) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            rad  <= rad_nx;
            rem  <= rem_nx;
            root <= root_nx;
            if (cnt == LAST) begin
              state    <= DONE;
              cnt      <= '0;
              res_o    <= root_nx[QW-1:GUARD_BITS];
              guard_o  <= root_nx[GUARD_BITS-1:0];
              sticky_o <= |rem_nx;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lamp_sqrt_radix_unit.sv
// Directed bench for lamp_sqrt_radix_unit: one instance at 1 bit/cycle and
// one at 2 bits/cycle, sharing operand inputs but with separate resets.
module tb_lamp_sqrt_radix_unit;

  logic       clk = 1'b0;
  logic       rst1, rst2;
  logic       do_sqrt, odd, special, flush;
  logic [7:0] s;

  logic       busy1, valid1, sticky1;
  logic [7:0] res1;
  logic [1:0] guard1;
  logic       busy2, valid2, sticky2;
  logic [7:0] res2;
  logic [1:0] guard2;

  logic       sel;
  logic       m_busy, m_valid, m_sticky;
  logic [7:0] m_res;
  logic [1:0] m_guard;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  lamp_sqrt_radix_unit #(.MANT_W(8), .GUARD_BITS(2), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst1), .doSqrt_i(do_sqrt), .s_i(s), .is_exp_odd_i(odd),
    .special_case_i(special), .flush_i(flush), .busy_o(busy1), .valid_o(valid1),
    .res_o(res1), .guard_o(guard1), .sticky_o(sticky1)
  );

  lamp_sqrt_radix_unit #(.MANT_W(8), .GUARD_BITS(2), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst2), .doSqrt_i(do_sqrt), .s_i(s), .is_exp_odd_i(odd),
    .special_case_i(special), .flush_i(flush), .busy_o(busy2), .valid_o(valid2),
    .res_o(res2), .guard_o(guard2), .sticky_o(sticky2)
  );

  assign m_busy   = sel ? busy2   : busy1;
  assign m_valid  = sel ? valid2  : valid1;
  assign m_res    = sel ? res2    : res1;
  assign m_guard  = sel ? guard2  : guard1;
  assign m_sticky = sel ? sticky2 : sticky1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Latency counts edges from the request cycle: the accept edge is 1.
  task automatic run_op(input string tag, input logic [7:0] sv, input logic ov, input logic sp,
                        input int exp_lat, input logic [7:0] er, input logic [1:0] eg, input logic es);
    int lat;
    s = sv; odd = ov; special = sp; do_sqrt = 1'b1;
    step();
    do_sqrt = 1'b0; s = 8'h5A; odd = ~ov; special = 1'b0;
    lat = 1;
    while (!m_valid && lat < 40) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".valid"}, m_valid, 1);
    check({tag, ".res"}, m_res, er);
    check({tag, ".guard"}, m_guard, eg);
    check({tag, ".sticky"}, m_sticky, es);
    step();
    check({tag, ".valid_drop"}, m_valid, 0);
    check({tag, ".busy_drop"}, m_busy, 0);
    step();
  endtask

  initial begin
    bit seen;
    rst1 = 1'b1; rst2 = 1'b1; do_sqrt = 1'b0; s = 8'h00; odd = 1'b0;
    special = 1'b0; flush = 1'b0; sel = 1'b0;
    step(); step();
    check("rst.busy", busy1, 0);
    check("rst.valid", valid1, 0);
    check("rst.res", res1, 0);
    check("rst.guard", guard1, 0);
    check("rst.sticky", sticky1, 0);
    check("rst2.all", {busy2, valid2, res2, guard2, sticky2}, 0);
    rst1 = 1'b0; rst2 = 1'b0;
    step();

    run_op("even80",  8'h80, 1'b0, 1'b0, 11, 8'h80, 2'b00, 1'b0);
    run_op("special", 8'h00, 1'b1, 1'b1,  1, 8'h00, 2'b00, 1'b0);
    run_op("c4",      8'hC4, 1'b0, 1'b0, 11, 8'h9E, 2'b01, 1'b1);
    run_op("odd80",   8'h80, 1'b1, 1'b0, 11, 8'hB5, 2'b00, 1'b1);

    // Flush mid-iteration: no strobe, previous result retained.
    s = 8'hC4; odd = 1'b0; do_sqrt = 1'b1;
    step();
    do_sqrt = 1'b0; s = 8'h5A;
    seen = 1'b0;
    repeat (3) begin
      if (valid1) seen = 1'b1;
      step();
    end
    check("flush.busy_before", busy1, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush.busy", busy1, 0);
    check("flush.valid", valid1, 0);
    check("flush.res", res1, 8'hB5);
    check("flush.guard", guard1, 2'b00);
    check("flush.sticky", sticky1, 1);
    repeat (12) begin
      if (valid1) seen = 1'b1;
      step();
    end
    check("flush.no_valid", seen, 0);
    run_op("post_flush", 8'h80, 1'b0, 1'b0, 11, 8'h80, 2'b00, 1'b0);

    do_sqrt = 1'b1; flush = 1'b1; s = 8'hC4;
    step();
    check("idle_flush.busy", busy1, 0);
    check("idle_flush.valid", valid1, 0);
    do_sqrt = 1'b0; flush = 1'b0;
    step();

    sel = 1'b1;
    run_op("bpc2_odd80", 8'h80, 1'b1, 1'b0, 6, 8'hB5, 2'b00, 1'b1);

    // Reset in the middle of an iteration on the 2-bit instance.
    s = 8'hC4; odd = 1'b0; do_sqrt = 1'b1;
    step();
    do_sqrt = 1'b0;
    step(); step();
    check("bpc2_rst.busy_before", busy2, 1);
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    check("bpc2_rst.busy", busy2, 0);
    check("bpc2_rst.valid", valid2, 0);
    check("bpc2_rst.res", res2, 0);
    check("bpc2_rst.guard", guard2, 0);
    check("bpc2_rst.sticky", sticky2, 0);
    seen = 1'b0;
    repeat (8) begin
      if (valid2) seen = 1'b1;
      step();
    end
    check("bpc2_rst.no_valid", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
